// File: rtl/vsd_pkg.sv
// Shared types and timing-window constants for the video sync decoder.
// Horizontal/vertical counts are the absolute 9-bit values from the timing generator.
package vsd_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_HOLD     = 2'd3
    } lock_state_e;

    localparam logic [8:0] H_MIN         = 9'd128;
    localparam logic [8:0] H_MAX         = 9'd511;
    localparam logic [8:0] H_SKIP        = 9'd228;
    localparam logic [8:0] H_ACT_START   = 9'd256;
    localparam logic [8:0] HSYNC_START   = 9'd176;
    localparam logic [8:0] HSYNC_END     = 9'd207;

    localparam logic [8:0] V_MAX         = 9'd511;
    localparam logic [8:0] V_ACT_START   = 9'd272;
    localparam logic [8:0] V_ACT_END     = 9'd495;
    localparam logic [8:0] VSYNC_START   = 9'd500;
    localparam logic [8:0] VSYNC_END     = 9'd503;
    localparam logic [8:0] V_RESTART_MIN = 9'd220;
    localparam logic [8:0] V_RESTART_MAX = 9'd251;

    localparam int unsigned LOCK_LINES = 4;
    localparam int          LINE_CNT_W = 3;
    localparam logic [LINE_CNT_W-1:0] LOCK_LAST = LINE_CNT_W'(LOCK_LINES - 1);

    typedef struct packed {
        logic hblank;
        logic vblank;
        logic hsync_n;
        logic vsync_n;
        logic de;
        logic frame_start;
        logic locked;
    } vsd_out_t;

    localparam vsd_out_t OUT_RST = '{
        hblank:      1'b1,
        vblank:      1'b1,
        hsync_n:     1'b1,
        vsync_n:     1'b1,
        de:          1'b0,
        frame_start: 1'b0,
        locked:      1'b0
    };

    function automatic logic in_window(input logic [8:0] x,
                                       input logic [8:0] lo,
                                       input logic [8:0] hi);
        return (x >= lo) && (x <= hi);
    endfunction

endpackage

// File: rtl/video_sync_decoder_if.sv
// Counter inputs, pixel enable and decoded sync outputs of the video sync decoder.
// master drives the counters (timing generator side); slave is the decoder.
interface video_sync_decoder_if;

    logic       i_EMU_CLK6MPCEN_n;
    logic [8:0] i_ABS_H_CNTR;
    logic [8:0] i_ABS_V_CNTR;

    logic       o_HBLANK;
    logic       o_VBLANK;
    logic       o_HSYNC_n;
    logic       o_VSYNC_n;
    logic       o_DE;
    logic       o_FRAME_START;
    logic       o_LOCKED;

    modport master (
        output i_EMU_CLK6MPCEN_n,
        output i_ABS_H_CNTR,
        output i_ABS_V_CNTR,
        input  o_HBLANK,
        input  o_VBLANK,
        input  o_HSYNC_n,
        input  o_VSYNC_n,
        input  o_DE,
        input  o_FRAME_START,
        input  o_LOCKED
    );

    modport slave (
        input  i_EMU_CLK6MPCEN_n,
        input  i_ABS_H_CNTR,
        input  i_ABS_V_CNTR,
        output o_HBLANK,
        output o_VBLANK,
        output o_HSYNC_n,
        output o_VSYNC_n,
        output o_DE,
        output o_FRAME_START,
        output o_LOCKED
    );

endinterface

// File: rtl/vsd_lock_fsm.sv
// Counter-step classifier and lock state machine; used only when
// VIDEO_SYNC_DECODER_LOCKDET_EN is defined. locked_next_o is the lock state after this sample.
module vsd_lock_fsm
    import vsd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [8:0] h_i,
    input  logic [8:0] v_i,
    output logic       locked_next_o
);

    lock_state_e            state_q;
    lock_state_e            state_d;
    logic                   prev_valid_q;
    logic [8:0]             prev_h_q;
    logic [8:0]             prev_v_q;
    logic [LINE_CNT_W-1:0]  line_cnt_q;
    logic [LINE_CNT_W-1:0]  line_cnt_d;

    logic line_wrap;
    logic frame_wrap;
    logic h_ok;
    logic v_ok;
    logic step_ok;
    logic line_done;

    // Increments are done 10 bits wide so prev=511 can never alias to 0.
    always_comb begin
        line_wrap  = (prev_h_q == H_MAX);
        frame_wrap = line_wrap && (prev_v_q == V_MAX);
        h_ok       = ({1'b0, h_i} == ({1'b0, prev_h_q} + 10'd1))
                   || (line_wrap && (h_i == H_MIN))
                   || (h_i == H_SKIP);
        if (!line_wrap) begin
            v_ok = (v_i == prev_v_q);
        end else if (!frame_wrap) begin
            v_ok = ({1'b0, v_i} == ({1'b0, prev_v_q} + 10'd1));
        end else begin
            v_ok = in_window(v_i, V_RESTART_MIN, V_RESTART_MAX);
        end
        step_ok   = h_ok && v_ok;
        line_done = step_ok && line_wrap;
    end

    always_comb begin
        state_d    = state_q;
        line_cnt_d = line_cnt_q;
        if (prev_valid_q) begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (step_ok) begin
                        state_d    = ST_ACQUIRE;
                        line_cnt_d = '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (!step_ok) begin
                        state_d = ST_UNLOCKED;
                    end else if (line_done) begin
                        if (line_cnt_q == LOCK_LAST) begin
                            state_d    = ST_LOCKED;
                            line_cnt_d = '0;
                        end else begin
                            line_cnt_d = line_cnt_q + 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!step_ok) begin
                        state_d    = ST_HOLD;
                        line_cnt_d = '0;
                    end
                end
                ST_HOLD: begin
                    if (!step_ok) begin
                        state_d = ST_UNLOCKED;
                    end else if (line_done) begin
                        state_d = ST_LOCKED;
                    end
                end
                default: begin
                    state_d    = ST_UNLOCKED;
                    line_cnt_d = '0;
                end
            endcase
        end
        locked_next_o = (state_d == ST_LOCKED) || (state_d == ST_HOLD);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_UNLOCKED;
            prev_valid_q <= 1'b0;
            prev_h_q     <= '0;
            prev_v_q     <= '0;
            line_cnt_q   <= '0;
        end else if (en_i) begin
            state_q      <= state_d;
            prev_valid_q <= 1'b1;
            prev_h_q     <= h_i;
            prev_v_q     <= v_i;
            line_cnt_q   <= line_cnt_d;
        end
    end

endmodule

// File: rtl/video_sync_decoder.sv
// Decodes blanking, sync, data-enable and frame-start from absolute H/V counts.
// Lock detection is built in only when VIDEO_SYNC_DECODER_LOCKDET_EN is defined.
module video_sync_decoder
    import vsd_pkg::*;
(
    input  logic                  i_EMU_MCLK,
    input  logic                  i_EMU_RST,
    video_sync_decoder_if.slave   bus
);

    logic       en;
    logic       locked_d;
    logic [8:0] h_cnt;
    logic [8:0] v_cnt;
    logic       hblank_raw;
    logic       vblank_raw;
    logic       hsync_raw_n;
    logic       vsync_raw_n;
    vsd_out_t   out_d;
    vsd_out_t   out_q;

    assign en    = ~bus.i_EMU_CLK6MPCEN_n;
    assign h_cnt = bus.i_ABS_H_CNTR;
    assign v_cnt = bus.i_ABS_V_CNTR;

`ifdef VIDEO_SYNC_DECODER_LOCKDET_EN
    vsd_lock_fsm u_lock_fsm (
        .clk_i         (i_EMU_MCLK),
        .rst_i         (i_EMU_RST),
        .en_i          (en),
        .h_i           (h_cnt),
        .v_i           (v_cnt),
        .locked_next_o (locked_d)
    );
`else
    // Without the detector the output reads locked from the first enabled cycle on.
    assign locked_d = 1'b1;
`endif

    // Gating uses the post-sample lock state so o_DE and o_LOCKED always agree.
    always_comb begin
        hblank_raw  = (h_cnt < H_ACT_START);
        hsync_raw_n = ~in_window(h_cnt, HSYNC_START, HSYNC_END);
        vblank_raw  = (v_cnt < V_ACT_START) || (v_cnt > V_ACT_END);
        vsync_raw_n = ~in_window(v_cnt, VSYNC_START, VSYNC_END);

        out_d             = OUT_RST;
        out_d.hblank      = hblank_raw  | ~locked_d;
        out_d.vblank      = vblank_raw  | ~locked_d;
        out_d.hsync_n     = hsync_raw_n | ~locked_d;
        out_d.vsync_n     = vsync_raw_n | ~locked_d;
        out_d.de          = ~hblank_raw & ~vblank_raw & locked_d;
        out_d.frame_start = (h_cnt == H_ACT_START) && (v_cnt == V_ACT_START) && locked_d;
        out_d.locked      = locked_d;
    end

    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_RST) begin
        if (i_EMU_RST) begin
            out_q <= OUT_RST;
        end else if (en) begin
            out_q <= out_d;
        end
    end

    assign bus.o_HBLANK      = out_q.hblank;
    assign bus.o_VBLANK      = out_q.vblank;
    assign bus.o_HSYNC_n     = out_q.hsync_n;
    assign bus.o_VSYNC_n     = out_q.vsync_n;
    assign bus.o_DE          = out_q.de;
    assign bus.o_FRAME_START = out_q.frame_start;
    assign bus.o_LOCKED      = out_q.locked;

endmodule
